cordic_vector_iter: RTL and testbench



---
 rtl/cordic_pkg.sv | 48 ++++
 rtl/cordic_vector_iter_if.sv | 27 ++
 rtl/cordic_microrot.sv | 35 +++
 rtl/cordic_vector_iter.sv | 126 ++++++++++++
 tb/tb_cordic_vector_iter.sv | 199 +++++++++++++++++++
 5 files changed

// File: rtl/cordic_pkg.sv
// rtl/cordic_pkg.sv - shared CORDIC types, arctangent table generator and width helpers
package cordic_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ITER,
    ST_COMP,
    ST_DONE
  } cordic_state_e;

  // x * (1/2 + 1/8 - 1/64 - 1/512) ~= x * 0.6074, undoing the CORDIC gain
  localparam int COMP_SH0 = 1;
  localparam int COMP_SH1 = 3;
  localparam int COMP_SH2 = 6;
  localparam int COMP_SH3 = 9;

  localparam longint TWO_PI_Q30      = 64'sd6746518852;
  localparam longint TWO_PI_Q30_HALF = TWO_PI_Q30 / 64'sd2;

  function automatic int coord_w(input int b);
    return b + 2;
  endfunction

  function automatic int mag_w(input int b);
    return b + 1;
  endfunction

  // round(atan(2^-i) * 2^a / (2*pi)) via a Q30 Taylor series; i=0 is exactly 2^a/8
  function automatic longint atan_lsb(input int a, input int i);
    longint t;
    longint t2;
    longint p;
    longint acc;
    if (i == 0) return longint'(1) << (a - 3);
    if (i >= 30) return 64'sd0;
    t   = longint'(1) << (30 - i);
    t2  = (t * t) >>> 30;
    p   = t;
    acc = 64'sd0;
    for (int k = 0; k < 24; k++) begin
      if (k % 2 == 0) acc = acc + p / longint'(2 * k + 1);
      else            acc = acc - p / longint'(2 * k + 1);
      p = (p * t2) >>> 30;
    end
    return ((acc << a) + TWO_PI_Q30_HALF) / TWO_PI_Q30;
  endfunction

endpackage

// File: rtl/cordic_vector_iter_if.sv
// rtl/cordic_vector_iter_if.sv - vector-in / magnitude+angle-out handshake bundle
interface cordic_vector_iter_if #(
  parameter int B = 14,
  parameter int A = 16
);
  import cordic_pkg::*;

  logic                  in_valid;
  logic                  in_ready;
  logic [2*B-1:0]        data_in;
  logic                  reflect_in;
  logic                  out_valid;
  logic                  out_ready;
  logic [mag_w(B)-1:0]   mag_out;
  logic [A-1:0]          angle_out;

  modport master (
    output in_valid, data_in, reflect_in, out_ready,
    input  in_ready, out_valid, mag_out, angle_out
  );

  modport slave (
    input  in_valid, data_in, reflect_in, out_ready,
    output in_ready, out_valid, mag_out, angle_out
  );

endinterface

// File: rtl/cordic_microrot.sv
// rtl/cordic_microrot.sv - one combinational CORDIC vectoring micro-rotation
module cordic_microrot #(
  parameter int W  = 16,
  parameter int A  = 16,
  parameter int SW = 4
) (
  input  logic signed [W-1:0] x,
  input  logic signed [W-1:0] y,
  input  logic        [A-1:0] z,
  input  logic       [SW-1:0] shift,
  input  logic        [A-1:0] atan_step,
  output logic signed [W-1:0] x_nxt,
  output logic signed [W-1:0] y_nxt,
  output logic        [A-1:0] z_nxt
);

  logic signed [W-1:0] xs;
  logic signed [W-1:0] ys;

  // both shifts use the pre-update coordinates
  always_comb begin
    xs = x >>> shift;
    ys = y >>> shift;
    if (!y[W-1]) begin
      x_nxt = x + ys;
      y_nxt = y - xs;
      z_nxt = z + atan_step;
    end else begin
      x_nxt = x - ys;
      y_nxt = y + xs;
      z_nxt = z - atan_step;
    end
  end

endmodule

// File: rtl/cordic_vector_iter.sv
// rtl/cordic_vector_iter.sv - iterative CORDIC vectoring engine; CORDIC_GAIN_COMP_EN adds gain compensation
module cordic_vector_iter
  import cordic_pkg::*;
#(
  parameter int B = 14,
  parameter int N = 12,
  parameter int A = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  cordic_vector_iter_if.slave  bus
);

  localparam int W  = coord_w(B);
  localparam int IW = $clog2(A);

  cordic_state_e       state;
  logic signed [W-1:0] x_q;
  logic signed [W-1:0] y_q;
  logic        [A-1:0] z_q;
  logic signed [W-1:0] x_nxt;
  logic signed [W-1:0] y_nxt;
  logic        [A-1:0] z_nxt;
  logic                refl_q;
  logic       [IW-1:0] cnt;
  logic                in_ready_q;
  logic                out_valid_q;
  logic          [B:0] mag_q;
  logic        [A-1:0] angle_q;
  logic        [A-1:0] atan_rom [2**IW];

  for (genvar g = 0; g < 2**IW; g++) begin : g_atan
    localparam logic [A-1:0] ATAN_G = A'(atan_lsb(A, g));
    assign atan_rom[g] = ATAN_G;
  end

  cordic_microrot #(.W(W), .A(A), .SW(IW)) u_microrot (
    .x         (x_q),
    .y         (y_q),
    .z         (z_q),
    .shift     (cnt),
    .atan_step (atan_rom[cnt]),
    .x_nxt     (x_nxt),
    .y_nxt     (y_nxt),
    .z_nxt     (z_nxt)
  );

`ifdef CORDIC_GAIN_COMP_EN
  logic signed [W-1:0] x_comp;
  assign x_comp = (x_q >>> COMP_SH0) + (x_q >>> COMP_SH1)
                - (x_q >>> COMP_SH2) - (x_q >>> COMP_SH3);
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      mag_q       <= '0;
      angle_q     <= '0;
      cnt         <= '0;
      x_q         <= '0;
      y_q         <= '0;
      z_q         <= '0;
      refl_q      <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (bus.in_valid) begin
            x_q        <= {{2{bus.data_in[2*B-1]}}, bus.data_in[2*B-1:B]};
            y_q        <= {{2{bus.data_in[B-1]}}, bus.data_in[B-1:0]};
            z_q        <= '0;
            refl_q     <= bus.reflect_in;
            cnt        <= '0;
            in_ready_q <= 1'b0;
            state      <= ST_ITER;
          end
        end
        ST_ITER: begin
          x_q <= x_nxt;
          y_q <= y_nxt;
          z_q <= z_nxt;
          cnt <= cnt + 1'b1;
          if (cnt == IW'(N - 1)) begin
`ifdef CORDIC_GAIN_COMP_EN
            state       <= ST_COMP;
`else
            // flipping the angle MSB adds pi to undo the upstream reflection
            state       <= ST_DONE;
            out_valid_q <= 1'b1;
            mag_q       <= x_nxt[B:0];
            angle_q     <= {z_nxt[A-1] ^ refl_q, z_nxt[A-2:0]};
`endif
          end
        end
`ifdef CORDIC_GAIN_COMP_EN
        ST_COMP: begin
          x_q         <= x_comp;
          state       <= ST_DONE;
          out_valid_q <= 1'b1;
          mag_q       <= x_comp[B:0];
          angle_q     <= {z_q[A-1] ^ refl_q, z_q[A-2:0]};
        end
`endif
        ST_DONE: begin
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state       <= ST_IDLE;
          end
        end
        default: begin
          state       <= ST_IDLE;
          in_ready_q  <= 1'b1;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.mag_out   = mag_q;
  assign bus.angle_out = angle_q;

endmodule

// File: tb/tb_cordic_vector_iter.sv
// tb/tb_cordic_vector_iter.sv - randomized bench for cordic_vector_iter against a polar-coordinate model
module tb_cordic_vector_iter;

  localparam int B = 14;
  localparam int N = 12;
  localparam int A = 16;
`ifdef CORDIC_GAIN_COMP_EN
  localparam int  LAT    = N + 2;
  localparam real COMP_F = 0.607421875;
`else
  localparam int  LAT    = N + 1;
  localparam real COMP_F = 1.0;
`endif
  localparam real PI          = 3.14159265358979323846;
  localparam real LSB_PER_RAD = 65536.0 / (2.0 * PI);

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  cordic_vector_iter_if #(.B(B), .A(A)) bus ();

  cordic_vector_iter #(.B(B), .N(N), .A(A)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input longint got, input longint exp, input longint tol);
    n_checks++;
    if (got - exp > tol || exp - got > tol) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d (+/-%0d)", tag, got, exp, tol);
    end
  endtask

  function automatic longint rnd(input real r);
    return longint'($rtoi(r >= 0.0 ? r + 0.5 : r - 0.5));
  endfunction

  function automatic real gain();
    real k;
    k = 1.0;
    for (int i = 0; i < N; i++) k = k * $sqrt(1.0 + 2.0 ** (-2 * i));
    return k * COMP_F;
  endfunction

  // expected angle moved to the 2*pi-equivalent closest to the observed one
  function automatic longint near(input longint got, input real exp_r);
    longint e;
    e = rnd(exp_r);
    while (got - e > 32768) e = e + 65536;
    while (e - got > 32768) e = e - 65536;
    return e;
  endfunction

  task automatic send(input int x, input int y, input bit refl);
    int t;
    t = 0;
    while (!bus.in_ready && t < 100) begin @(posedge clk); #1; t++; end
    check("send_ready", bus.in_ready, 1, 0);
    bus.data_in    = {B'(x), B'(y)};
    bus.reflect_in = refl;
    bus.in_valid   = 1'b1;
    @(posedge clk); #1;
    bus.in_valid   = 1'b0;
  endtask

  task automatic wait_out(output int lat);
    lat = 1;
    while (!bus.out_valid && lat < 200) begin @(posedge clk); #1; lat++; end
  endtask

  task automatic check_result(input string tag, input int x, input int y, input bit refl,
                              input int mtol, input int atol);
    real    em;
    real    ea;
    longint ga;
    em = gain() * $sqrt(real'(x) * real'(x) + real'(y) * real'(y));
    ea = $atan2(real'(y), real'(x)) * LSB_PER_RAD + (refl ? 32768.0 : 0.0);
    ga = longint'($signed(bus.angle_out));
    check({tag, "_mag"}, longint'(bus.mag_out), rnd(em), longint'(mtol));
    check({tag, "_ang"}, ga, near(ga, ea), longint'(atol));
  endtask

  task automatic accept(input int dly);
    repeat (dly) begin @(posedge clk); #1; end
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    check("release_valid", bus.out_valid, 0, 0);
    check("release_ready", bus.in_ready, 1, 0);
  endtask

  task automatic run_vec(input string tag, input int x, input int y, input bit refl,
                         input int mtol, input int atol, input int dly);
    int lat;
    send(x, y, refl);
    wait_out(lat);
    check({tag, "_lat"}, lat, LAT, 0);
    check_result(tag, x, y, refl, mtol, atol);
    accept(dly);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int     x;
    int     y;
    int     lat;
    int     seen;
    longint zsum;

    bus.in_valid   = 1'b0;
    bus.out_ready  = 1'b0;
    bus.data_in    = '0;
    bus.reflect_in = 1'b0;
    rst            = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready", bus.in_ready, 1, 0);
    check("rst_out_valid", bus.out_valid, 0, 0);
    check("rst_mag", longint'(bus.mag_out), 0, 0);
    check("rst_angle", longint'(bus.angle_out), 0, 0);
    rst = 1'b0;
    @(posedge clk); #1;

    run_vec("x_axis",   4096,     0, 1'b0, 6, 8, 0);
    run_vec("y_axis",      0,  4096, 1'b0, 6, 8, 1);
    run_vec("diag_neg", 4096, -4096, 1'b0, 8, 8, 0);
    run_vec("refl_x",   4096,     0, 1'b1, 6, 8, 2);
    run_vec("refl_diag",4096,  4096, 1'b1, 8, 8, 0);

    // zero vector: every step takes the y>=0 path, angle is the sum of the table
    zsum = 0;
    for (int i = 0; i < N; i++) zsum = zsum + rnd($atan(2.0 ** (-i)) * LSB_PER_RAD);
    send(0, 0, 1'b0);
    wait_out(lat);
    check("zero_lat", lat, LAT, 0);
    check("zero_mag", longint'(bus.mag_out), 0, 0);
    check("zero_ang", longint'($signed(bus.angle_out)), zsum, 0);
    accept(0);

    // result held under back-pressure, in_valid pulse ignored while busy
    send(3000, -1000, 1'b0);
    wait_out(lat);
    check("hold_lat", lat, LAT, 0);
    for (int c = 0; c < 20; c++) begin
      if (c == 5) begin
        bus.in_valid = 1'b1;
        bus.data_in  = {B'(100), B'(5000)};
      end
      if (c == 6) bus.in_valid = 1'b0;
      check("hold_valid", bus.out_valid, 1, 0);
      check("hold_ready", bus.in_ready, 0, 0);
      check_result("hold", 3000, -1000, 1'b0, 12, 24);
      @(posedge clk); #1;
    end
    bus.in_valid = 1'b0;
    accept(0);
    seen = 0;
    repeat (20) begin @(posedge clk); #1; if (bus.out_valid) seen = 1; end
    check("busy_not_captured", seen, 0, 0);

    // synchronous reset in the middle of iterating
    send(4096, 4096, 1'b1);
    repeat (5) begin @(posedge clk); #1; end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("abort_valid", bus.out_valid, 0, 0);
    check("abort_ready", bus.in_ready, 1, 0);
    check("abort_mag", longint'(bus.mag_out), 0, 0);
    check("abort_angle", longint'(bus.angle_out), 0, 0);
    seen = 0;
    repeat (20) begin @(posedge clk); #1; if (bus.out_valid) seen = 1; end
    check("abort_quiet", seen, 0, 0);
    run_vec("after_abort", 4096, 0, 1'b0, 6, 8, 0);

    for (int v = 0; v < 30; v++) begin
      do begin
        x = int'($urandom_range(8191, 0));
        y = int'($urandom_range(16383, 0)) - 8192;
      end while (x * x + y * y < 2048 * 2048);
      run_vec("rand", x, y, 1'($urandom_range(1, 0)), 12, 24, int'($urandom_range(3, 0)));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
